// File: rtl/enc_sample_sched_pkg.sv
// Shared types and constants for the encoder sample scheduler.
// Holds the FSM state type, the reset sample period and the minimum legal period.
package enc_sample_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // 3.2 ms at 50 MHz
  localparam int unsigned PER_DEF_C = 160000;
  localparam int unsigned MIN_PER   = 2;

endpackage

// File: rtl/enc_period_timer.sv
// Programmable sample-period counter producing a one-cycle tick.
// Period loads are clamped to MIN_PER and restart the count from zero.
module enc_period_timer
  import enc_sample_sched_pkg::*;
#(
  parameter int unsigned PER_W   = 18,
  parameter int unsigned PER_DEF = PER_DEF_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PER_W-1:0] period_in,
  input  logic             period_load,
  output logic             tick
);

  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] w_cnt_nxt;
  logic [PER_W-1:0] w_period_nxt;
  logic [PER_W-1:0] w_period_clamped;
  logic             w_last;

  assign w_last           = (r_cnt == (r_period - PER_W'(1)));
  assign tick             = enable && w_last;
  assign w_period_clamped = (period_in < PER_W'(MIN_PER)) ? PER_W'(MIN_PER) : period_in;

  // A load restarts the count even when it coincides with a tick
  always_comb begin
    w_cnt_nxt    = r_cnt + PER_W'(1);
    w_period_nxt = r_period;
    if (period_load) begin
      w_period_nxt = w_period_clamped;
      w_cnt_nxt    = '0;
    end else if (!enable || w_last) begin
      w_cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_period <= PER_W'(PER_DEF);
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
    end
  end

endmodule

// File: rtl/enc_sample_sched.sv
// Encoder sample scheduler: snapshots all channel counts on each period tick,
// clears the encoders, then streams the snapshot out channel by channel.
module enc_sample_sched
  import enc_sample_sched_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = 16,
  parameter  int unsigned PER_W   = 18,
  parameter  int unsigned PER_DEF = PER_DEF_C,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PER_W-1:0]      period_in,
  input  logic                  period_load,
  input  logic [N_CH*CNT_W-1:0] cnt_in,
  output logic [N_CH-1:0]       clr_out,
  output logic [CH_W-1:0]       out_ch,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  tick,
  output logic                  overrun,
  input  logic                  ovr_clr
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W-1:0]  r_idx;
  logic [CH_W-1:0]  w_idx_nxt;
  logic [CH_W-1:0]  w_idx_inc;
  logic [CNT_W-1:0] r_shadow     [N_CH];
  logic [CNT_W-1:0] w_shadow_nxt [N_CH];
  logic             r_out_valid;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [N_CH-1:0]  r_clr;
  logic [N_CH-1:0]  w_clr_nxt;
  logic             r_overrun;
  logic             w_ovr_nxt;
  logic             w_tick;
  logic             w_last;

  enc_period_timer #(
    .PER_W   (PER_W),
    .PER_DEF (PER_DEF)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period_in   (period_in),
    .period_load (period_load),
    .tick        (w_tick)
  );

  assign tick      = w_tick;
  assign clr_out   = r_clr;
  assign out_ch    = r_idx;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

  assign w_idx_inc = r_idx + CH_W'(1);
  assign w_last    = (r_idx == CH_W'(N_CH - 1));

  // Next-state, snapshot and handshake sequencing
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_valid_nxt  = r_out_valid;
    w_count_nxt  = r_out_count;
    w_clr_nxt    = '0;
    w_ovr_nxt    = r_overrun;

    case (r_state)
      IDLE: begin
        if (w_tick) begin
          for (int i = 0; i < N_CH; i++) begin
            w_shadow_nxt[i] = cnt_in[i*CNT_W +: CNT_W];
          end
          w_state_nxt = SEND;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_count_nxt = cnt_in[CNT_W-1:0];
          w_clr_nxt   = '1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_count_nxt = r_shadow[w_idx_inc];
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    // A tick that finds a transfer in flight wins over a clear request
    if (ovr_clr) begin
      w_ovr_nxt = 1'b0;
    end
    if (w_tick && (r_state == SEND)) begin
      w_ovr_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_clr       <= '0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_count <= w_count_nxt;
      r_clr       <= w_clr_nxt;
      r_overrun   <= w_ovr_nxt;
      r_shadow    <= w_shadow_nxt;
    end
  end

endmodule

// File: tb/tb_enc_sample_sched.sv
// Self-checking bench for enc_sample_sched: directed scenarios plus randomized
// traffic checked against a tick-schedule / FIFO reference model.
module tb_enc_sample_sched;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 16;
  localparam int PER_W   = 18;
  // Shortened reset period keeps the post-reset tick check brief
  localparam int PER_DEF = 1000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [PER_W-1:0]      period_in;
  logic                  period_load;
  logic [N_CH*CNT_W-1:0] cnt_in;
  logic [N_CH-1:0]       clr_out;
  logic [1:0]            out_ch;
  logic [CNT_W-1:0]      out_count;
  logic                  out_valid;
  logic                  out_ready;
  logic                  tick;
  logic                  overrun;
  logic                  ovr_clr;

  always #5 clk = ~clk;

  enc_sample_sched #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .PER_W   (PER_W),
    .PER_DEF (PER_DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period_in   (period_in),
    .period_load (period_load),
    .cnt_in      (cnt_in),
    .clr_out     (clr_out),
    .out_ch      (out_ch),
    .out_count   (out_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .tick        (tick),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
  } item_t;

  // Reference model: ticks land where (cycle - anchor) mod period == period-1;
  // a snapshot is a queue of pending (channel, value) words.
  item_t q[$];
  int    cyc    = 0;
  int    anchor = 0;
  int    per_m  = PER_DEF;
  bit    ovr_m  = 1'b0;
  bit    clr_pend = 1'b0;

  bit          exp_tick, exp_valid, exp_ovr;
  logic [3:0]  exp_clr;
  logic [1:0]  exp_ch;
  logic [15:0] exp_cnt;
  logic        obs_tick, obs_valid, obs_ovr;
  logic [3:0]  obs_clr;
  logic [1:0]  obs_ch;
  logic [15:0] obs_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Advance one clock: predict and sample this cycle, then apply the edge to the model
  task automatic step();
    bit busy;
    @(negedge clk);
    exp_tick  = enable && (((cyc - anchor) % per_m) == (per_m - 1));
    exp_valid = (q.size() != 0);
    exp_ch    = exp_valid ? q[0].ch  : 2'd0;
    exp_cnt   = exp_valid ? q[0].val : 16'd0;
    exp_clr   = clr_pend ? 4'hF : 4'h0;
    exp_ovr   = ovr_m;
    obs_tick  = tick;
    obs_valid = out_valid;
    obs_ovr   = overrun;
    obs_clr   = clr_out;
    obs_ch    = out_ch;
    obs_cnt   = out_count;
    if (rst) begin
      per_m    = PER_DEF;
      anchor   = cyc + 1;
      q.delete();
      ovr_m    = 1'b0;
      clr_pend = 1'b0;
    end else begin
      busy = (q.size() != 0);
      if (busy && out_ready) void'(q.pop_front());
      clr_pend = exp_tick && !busy;
      if (exp_tick && !busy) begin
        for (int i = 0; i < N_CH; i++) begin
          item_t it;
          it.ch  = 2'(i);
          it.val = cnt_in[i*CNT_W +: CNT_W];
          q.push_back(it);
        end
      end
      if (exp_tick && busy) ovr_m = 1'b1;
      else if (ovr_clr) ovr_m = 1'b0;
      if (period_load) begin
        per_m  = (period_in < 2) ? 2 : int'(period_in);
        anchor = cyc + 1;
      end else if (!enable) begin
        anchor = cyc + 1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int per);
    rst = 1'b1; enable = 1'b0; period_load = 1'b0; ovr_clr = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0; enable = 1'b1; period_in = PER_W'(per); period_load = 1'b1;
    step();
    period_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; period_load = 1'b1; period_in = 18'd3;
    ovr_clr = 1'b1; out_ready = 1'b1; cnt_in = {$urandom, $urandom};
    step();
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", obs_valid); end
    n_cmp++; if (obs_clr !== 4'h0) begin n_bad++; $display("FAIL reset_clr got %h want 0", obs_clr); end
    n_cmp++; if (obs_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", obs_ovr); end
    n_cmp++; if (obs_ch !== 2'd0) begin n_bad++; $display("FAIL reset_ch got %0d want 0", obs_ch); end
    n_cmp++; if (obs_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_count got %h want 0", obs_cnt); end
    n_cmp++; if (obs_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", obs_tick); end
    rst = 1'b0; period_load = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic test_period();
    setup(10);
    for (int rel = 1; rel <= 45; rel++) begin
      bit wt, wv;
      logic [3:0] wc;
      cnt_in = {$urandom, $urandom};
      step();
      wt = (rel % 10 == 0);
      wc = (rel > 10 && rel % 10 == 1) ? 4'hF : 4'h0;
      wv = (rel > 10 && (rel - 1) % 10 < 4);
      n_cmp++; if (obs_tick !== wt) begin n_bad++; $display("FAIL period_tick rel=%0d got %b want %b", rel, obs_tick, wt); end
      n_cmp++; if (obs_clr !== wc) begin n_bad++; $display("FAIL period_clr rel=%0d got %h want %h", rel, obs_clr, wc); end
      n_cmp++; if (obs_valid !== wv) begin n_bad++; $display("FAIL period_valid rel=%0d got %b want %b", rel, obs_valid, wv); end
      n_cmp++; if (obs_ovr !== 1'b0) begin n_bad++; $display("FAIL period_ovr rel=%0d got %b want 0", rel, obs_ovr); end
      if (wv && exp_valid) begin
        n_cmp++;
        if ({obs_ch, obs_cnt} !== {exp_ch, exp_cnt}) begin
          n_bad++; $display("FAIL period_data rel=%0d got %0d/%h want %0d/%h", rel, obs_ch, obs_cnt, exp_ch, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_snapshot_order();
    setup(10);
    for (int rel = 1; rel <= 15; rel++) begin
      cnt_in = (rel == 10) ? {16'h0044, 16'h0033, 16'h0022, 16'h0011} : {$urandom, $urandom};
      step();
      if (rel == 10) begin
        n_cmp++; if (obs_tick !== 1'b1) begin n_bad++; $display("FAIL snap_tick got %b want 1", obs_tick); end
      end
      if (rel >= 11 && rel <= 14) begin
        logic [1:0]  wch;
        logic [15:0] wcnt;
        wch  = 2'(rel - 11);
        wcnt = 16'(16'h0011 * (rel - 10));
        n_cmp++; if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL snap_valid rel=%0d got %b want 1", rel, obs_valid); end
        n_cmp++; if (obs_ch !== wch) begin n_bad++; $display("FAIL snap_ch rel=%0d got %0d want %0d", rel, obs_ch, wch); end
        n_cmp++; if (obs_cnt !== wcnt) begin n_bad++; $display("FAIL snap_count rel=%0d got %h want %h", rel, obs_cnt, wcnt); end
      end
      if (rel == 11) begin
        n_cmp++; if (obs_clr !== 4'hF) begin n_bad++; $display("FAIL snap_clr got %h want f", obs_clr); end
      end
      if (rel == 15) begin
        n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL snap_end_valid got %b want 0", obs_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = 16'($urandom);
    setup(10);
    for (int rel = 1; rel <= 19; rel++) begin
      bit wv;
      int wch;
      if (rel == 10) for (int i = 0; i < 4; i++) cnt_in[i*CNT_W +: CNT_W] = vals[i];
      else cnt_in = {$urandom, $urandom};
      out_ready = !(rel >= 12 && rel <= 14);
      step();
      wv = (rel >= 11 && rel <= 17);
      wch = (rel == 11) ? 0 : (rel <= 15) ? 1 : (rel == 16) ? 2 : 3;
      n_cmp++; if (obs_valid !== wv) begin n_bad++; $display("FAIL bp_valid rel=%0d got %b want %b", rel, obs_valid, wv); end
      if (wv) begin
        n_cmp++; if (obs_ch !== 2'(wch)) begin n_bad++; $display("FAIL bp_ch rel=%0d got %0d want %0d", rel, obs_ch, wch); end
        n_cmp++; if (obs_cnt !== vals[wch]) begin n_bad++; $display("FAIL bp_count rel=%0d got %h want %h", rel, obs_cnt, vals[wch]); end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_overrun();
    logic [15:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = 16'($urandom);
    setup(3);
    for (int rel = 1; rel <= 18; rel++) begin
      bit wt, wo, wv;
      logic [3:0] wc;
      if (rel == 3) for (int i = 0; i < 4; i++) cnt_in[i*CNT_W +: CNT_W] = vals[i];
      else cnt_in = {$urandom, $urandom};
      enable    = !(rel == 7 || rel == 8);
      ovr_clr   = (rel == 8 || rel == 11);
      out_ready = (rel >= 13);
      step();
      wt = (rel == 3 || rel == 6 || rel == 11 || rel == 14 || rel == 17);
      wo = (rel == 7 || rel == 8 || rel >= 12);
      wv = (rel >= 4 && rel <= 16) || rel == 18;
      wc = (rel == 4 || rel == 18) ? 4'hF : 4'h0;
      n_cmp++; if (obs_tick !== wt) begin n_bad++; $display("FAIL ovr_tick rel=%0d got %b want %b", rel, obs_tick, wt); end
      n_cmp++; if (obs_ovr !== wo) begin n_bad++; $display("FAIL ovr_flag rel=%0d got %b want %b", rel, obs_ovr, wo); end
      n_cmp++; if (obs_clr !== wc) begin n_bad++; $display("FAIL ovr_clr_out rel=%0d got %h want %h", rel, obs_clr, wc); end
      n_cmp++; if (obs_valid !== wv) begin n_bad++; $display("FAIL ovr_valid rel=%0d got %b want %b", rel, obs_valid, wv); end
      if (rel >= 4 && rel <= 16) begin
        int wch;
        wch = (rel <= 13) ? 0 : rel - 13;
        n_cmp++;
        if ({obs_ch, obs_cnt} !== {2'(wch), vals[wch]}) begin
          n_bad++; $display("FAIL ovr_data rel=%0d got %0d/%h want %0d/%h", rel, obs_ch, obs_cnt, wch, vals[wch]);
        end
      end
    end
    enable = 1'b1; ovr_clr = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_clamp_enable();
    setup(0);
    for (int rel = 1; rel <= 22; rel++) begin
      bit wt;
      if (rel == 12) begin period_in = 18'd5; period_load = 1'b1; end
      step();
      period_load = 1'b0;
      wt = (rel <= 12) ? (rel % 2 == 0) : (rel == 17 || rel == 22);
      n_cmp++; if (obs_tick !== wt) begin n_bad++; $display("FAIL clamp_tick rel=%0d got %b want %b", rel, obs_tick, wt); end
    end
    enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      n_cmp++; if (obs_tick !== 1'b0) begin n_bad++; $display("FAIL disabled_tick k=%0d got %b want 0", k, obs_tick); end
    end
    enable = 1'b1; period_in = 18'd1; period_load = 1'b1;
    step();
    period_load = 1'b0;
    for (int rel = 1; rel <= 8; rel++) begin
      step();
      n_cmp++; if (obs_tick !== (rel % 2 == 0)) begin n_bad++; $display("FAIL clamp1_tick rel=%0d got %b want %b", rel, obs_tick, rel % 2 == 0); end
    end
  endtask

  task automatic test_reset_mid_send();
    setup(10);
    for (int rel = 1; rel <= 21; rel++) begin
      cnt_in = {$urandom, $urandom};
      out_ready = (rel == 11 || rel == 12);
      step();
    end
    rst = 1'b1; period_in = 18'd7; period_load = 1'b1; ovr_clr = 1'b1; out_ready = 1'b0;
    step();
    n_cmp++; if ({obs_valid, obs_ch, obs_ovr} !== {1'b1, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL midsend_pre got v=%b ch=%0d ovr=%b want v=1 ch=2 ovr=1", obs_valid, obs_ch, obs_ovr);
    end
    rst = 1'b0; period_load = 1'b0; ovr_clr = 1'b0; out_ready = 1'b1; enable = 1'b1;
    for (int k = 1; k <= PER_DEF + 2; k++) begin
      step();
      if (k == 1) begin
        n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL midsend_valid got %b want 0", obs_valid); end
        n_cmp++; if (obs_ovr !== 1'b0) begin n_bad++; $display("FAIL midsend_ovr got %b want 0", obs_ovr); end
      end
      if (obs_tick !== (k == PER_DEF)) begin
        n_cmp++; n_bad++; $display("FAIL midsend_tick k=%0d got %b want %b", k, obs_tick, k == PER_DEF);
      end else if (k == PER_DEF) begin
        n_cmp++;
      end
    end
  endtask

  task automatic test_random();
    setup(5);
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom % 500 == 0);
      enable      = ($urandom % 16 != 0);
      period_load = ($urandom % 40 == 0);
      period_in   = PER_W'($urandom_range(0, 12));
      out_ready   = ($urandom % 4 != 0);
      ovr_clr     = ($urandom % 16 == 0);
      cnt_in      = {$urandom, $urandom};
      step();
      n_cmp++; if (obs_tick !== exp_tick) begin n_bad++; $display("FAIL rnd_tick cyc=%0d got %b want %b", cyc, obs_tick, exp_tick); end
      n_cmp++; if (obs_clr !== exp_clr) begin n_bad++; $display("FAIL rnd_clr cyc=%0d got %h want %h", cyc, obs_clr, exp_clr); end
      n_cmp++; if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, obs_valid, exp_valid); end
      n_cmp++; if (obs_ovr !== exp_ovr) begin n_bad++; $display("FAIL rnd_ovr cyc=%0d got %b want %b", cyc, obs_ovr, exp_ovr); end
      if (exp_valid) begin
        n_cmp++;
        if ({obs_ch, obs_cnt} !== {exp_ch, exp_cnt}) begin
          n_bad++; $display("FAIL rnd_data cyc=%0d got %0d/%h want %0d/%h", cyc, obs_ch, obs_cnt, exp_ch, exp_cnt);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period_in = '0; period_load = 1'b0;
    cnt_in = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    test_reset();
    test_period();
    test_snapshot_order();
    test_backpressure();
    test_overrun();
    test_clamp_enable();
    test_reset_mid_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enc_sample_sched.md
ENC_SAMPLE_SCHED -- requirements
Module: enc_sample_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_CH  4  number of encoder channels
  CNT_W  16  encoder count width
  PER_W  18  sample-period counter width
  PER_DEF  160000  reset period in clk cycles (3.2 ms at 50 MHz)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  enable  in  1  sampling enable
  period_in  in  PER_W  new sample period
  period_load  in  1  one-cycle strobe: load period_in
  cnt_in  in  N_CH*CNT_W  live encoder counts, channel 0 in LSBs
  clr_out  out  N_CH  one-cycle clear pulse to encoder counters
  out_ch  out  clog2(N_CH)  channel index of out_count
  out_count  out  CNT_W  sampled count
  out_valid  out  1  out_count/out_ch valid
  out_ready  in  1  consumer accepts when high with out_valid
  tick  out  1  one-cycle sample-instant pulse
  overrun  out  1  sticky: tick occurred while still sending
  ovr_clr  in  1  clears overrun

Function
REQ-003 Period counter SHALL count 0..period_reg-1 while enable=1; tick=1 in the cycle count==period_reg-1, counter wraps to 0 next cycle.
REQ-004 enable=0 SHALL hold counter at 0 and suppress tick; an in-progress send SHALL still complete.
REQ-005 period_load SHALL write period_reg and reset the counter to 0 the next cycle; values below 2 SHALL be clamped to 2.
REQ-006 FSM states: IDLE, SEND. tick in IDLE: at the next edge all N_CH counts SHALL be latched into shadow registers, clr_out SHALL be all-ones for exactly that one cycle (cycle after tick), state -> SEND with index 0.
REQ-007 In SEND, out_valid=1, out_ch=index, out_count=shadow[index]; values SHALL stay stable until out_valid&&out_ready.
REQ-008 On handshake with index<N_CH-1: index+1 next cycle, out_valid stays 1; with index=N_CH-1: state -> IDLE, out_valid=0 next cycle.
REQ-009 Minimum latency: tick at cycle T -> out_valid=1 with channel 0 at T+1; with out_ready held 1, last channel accepted at T+N_CH.
REQ-010 tick while in SEND SHALL NOT latch shadows nor pulse clr_out (encoders keep accumulating); overrun SHALL be set at the next edge.
REQ-011 tick coincident with final handshake (SEND, index N_CH-1, out_ready=1) SHALL count as in SEND: overrun set, no new snapshot.
REQ-012 ovr_clr SHALL clear overrun; simultaneous set and ovr_clr SHALL leave overrun=1.
REQ-013 period_load coincident with tick: tick still issued, counter restarts at 0 with new period.

Reset
REQ-014 rst SHALL force: period_reg=PER_DEF, counter=0, state IDLE, index=0, shadows=0, out_valid=0, out_ch=0, out_count=0, clr_out=0, tick=0, overrun=0.
REQ-015 rst mid-SEND SHALL abandon the transfer; out_valid=0 the cycle after rst is sampled.
REQ-016 rst SHALL dominate period_load, ovr_clr and tick.

Structure
REQ-017 Shared package SHALL hold state enum {IDLE, SEND}, PER_DEF, and minimum-period constant 2.
REQ-018 Period counter/tick generator SHALL be a sub-module enc_period_timer (clk, rst, enable, period_in, period_load, tick); FSM, shadows, handshake in top.

Verification
REQ-019 Period: rst, period_load=10, enable=1, out_ready=1 -> tick every 10 cycles, first 10 cycles after load; clr_out=4'b1111 one cycle after each tick.
REQ-020 Snapshot/order: cnt_in ch0..3 = 0x0011,0x0022,0x0033,0x0044 at tick -> outputs (0,0x0011),(1,0x0022),(2,0x0033),(3,0x0044) on consecutive cycles T+1..T+4.
REQ-021 Backpressure: out_ready low 3 cycles on ch1 -> ch1 value/index held stable, no skip or duplicate, order preserved.
REQ-022 Overrun: period=3, out_ready=0 -> second tick sets overrun, clr_out not pulsed, shadows unchanged; ovr_clr clears it.
REQ-023 Reset mid-send: rst at index 2 -> out_valid=0, period_reg=160000, overrun=0 next cycle; next tick after 160000 enabled cycles.
REQ-024 Clamp/enable: period_load=0 -> tick every 2 cycles; enable=0 -> no tick for 50 cycles.
